// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types, constants and field layout for the MMU burst sequencer
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [1:0] WRITE_REG     = 2'b10;
  localparam logic [1:0] WRITE_NONE    = 2'b00;
  localparam logic [2:0] SL_OP_DEFAULT = 3'b111;

  // Instruction fields are packed LSB-first: st, ld, reg, mem, sel, len.
  localparam int ST_POS  = 0;
  localparam int LD_POS  = 1;
  localparam int REG_POS = 2;

  function automatic int mem_pos(input int reg_aw);
    return REG_POS + reg_aw;
  endfunction

  function automatic int sel_pos(input int reg_aw, input int mem_aw);
    return mem_pos(reg_aw) + mem_aw;
  endfunction

  function automatic int len_pos(input int reg_aw, input int mem_aw, input int sel_w);
    return sel_pos(reg_aw, mem_aw) + sel_w;
  endfunction

  function automatic int used_w(input int reg_aw, input int mem_aw, input int sel_w,
                                input int burst_w);
    return len_pos(reg_aw, mem_aw, sel_w) + burst_w;
  endfunction

endpackage

// File: rtl/mmu_burst_sequencer_if.sv
// rtl/mmu_burst_sequencer_if.sv - issue-side and memory-side signals of the burst sequencer
interface mmu_burst_sequencer_if #(
  parameter int INSTR_W = 30,
  parameter int REG_AW  = 4,
  parameter int MEM_AW  = 4,
  parameter int SEL_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               invalid_instruction;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [MEM_AW-1:0]  mem_addr;
  logic               st;
  logic               ld;
  logic               mem_rvalid;
  logic [REG_AW-1:0]  reg_addr;
  logic [SEL_W-1:0]   sl_select;
  logic [2:0]         sl_op;
  logic [1:0]         write;
  logic               busy;

  modport slave (
    input  in_valid, instruction, mem_req_ready, mem_rvalid,
    output in_ready, invalid_instruction, mem_req_valid, mem_addr, st, ld,
           reg_addr, sl_select, sl_op, write, busy
  );

  modport master (
    output in_valid, instruction, mem_req_ready, mem_rvalid,
    input  in_ready, invalid_instruction, mem_req_valid, mem_addr, st, ld,
           reg_addr, sl_select, sl_op, write, busy
  );
endinterface

// File: rtl/mmu_field_decode.sv
// rtl/mmu_field_decode.sv - combinational split of an instruction into load/store fields
module mmu_field_decode
  import mmu_pkg::*;
#(
  parameter int INSTR_W = 30,
  parameter int REG_AW  = 4,
  parameter int MEM_AW  = 4,
  parameter int SEL_W   = 4,
  parameter int BURST_W = 2
) (
  input  logic [INSTR_W-1:0] instruction,
  output logic               st,
  output logic               ld,
  output logic [REG_AW-1:0]  reg_f,
  output logic [MEM_AW-1:0]  mem_f,
  output logic [SEL_W-1:0]   sel_f,
  output logic [BURST_W-1:0] len_f,
  output logic               valid_op
);
  localparam int MEM_LSB = mem_pos(REG_AW);
  localparam int SEL_LSB = sel_pos(REG_AW, MEM_AW);
  localparam int LEN_LSB = len_pos(REG_AW, MEM_AW, SEL_W);
  localparam int USED_W  = used_w(REG_AW, MEM_AW, SEL_W, BURST_W);

  assign st       = instruction[ST_POS];
  assign ld       = instruction[LD_POS];
  assign reg_f    = instruction[REG_POS +: REG_AW];
  assign mem_f    = instruction[MEM_LSB +: MEM_AW];
  assign sel_f    = instruction[SEL_LSB +: SEL_W];
  assign len_f    = instruction[LEN_LSB +: BURST_W];
  assign valid_op = ld ^ st;

  // Bits above the packed fields are reserved and deliberately ignored.
  generate
    if (INSTR_W > USED_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^instruction[INSTR_W-1:USED_W];
    end
  endgenerate

endmodule

// File: rtl/mmu_burst_sequencer.sv
// rtl/mmu_burst_sequencer.sv - sequential load/store burst engine between issue and data memory
module mmu_burst_sequencer
  import mmu_pkg::*;
#(
  parameter int INSTR_W = 30,
  parameter int REG_AW  = 4,
  parameter int MEM_AW  = 4,
  parameter int SEL_W   = 4,
  parameter int BURST_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  mmu_burst_sequencer_if.slave bus
);
  state_t state_q, state_d;

  logic               st_q, ld_q, invalid_q;
  logic [REG_AW-1:0]  reg_q;
  logic [MEM_AW-1:0]  mem_q;
  logic [SEL_W-1:0]   sel_q;
  logic [BURST_W-1:0] len_q, cnt_q;

  logic               dec_st, dec_ld, dec_valid;
  logic [REG_AW-1:0]  dec_reg;
  logic [MEM_AW-1:0]  dec_mem;
  logic [SEL_W-1:0]   dec_sel;
  logic [BURST_W-1:0] dec_len;

  logic accept, beat_done, last_beat;

  mmu_field_decode #(
    .INSTR_W (INSTR_W),
    .REG_AW  (REG_AW),
    .MEM_AW  (MEM_AW),
    .SEL_W   (SEL_W),
    .BURST_W (BURST_W)
  ) u_decode (
    .instruction (bus.instruction),
    .st          (dec_st),
    .ld          (dec_ld),
    .reg_f       (dec_reg),
    .mem_f       (dec_mem),
    .sel_f       (dec_sel),
    .len_f       (dec_len),
    .valid_op    (dec_valid)
  );

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_beat = (cnt_q == len_q);

  // A store beat ends on the request handshake, a load beat on returned data.
  always_comb begin
    beat_done = 1'b0;
    case (state_q)
      ISSUE:   beat_done = bus.mem_req_ready && st_q;
      WAIT_RD: beat_done = bus.mem_rvalid;
      default: beat_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && dec_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          if (ld_q)           state_d = WAIT_RD;
          else if (last_beat) state_d = IDLE;
          else                state_d = ISSUE;
        end
      end
      WAIT_RD: begin
        if (bus.mem_rvalid) state_d = last_beat ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready      = 1'b0;
    bus.busy          = 1'b1;
    bus.mem_req_valid = 1'b0;
    bus.write         = WRITE_NONE;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      ISSUE:   bus.mem_req_valid = 1'b1;
      WAIT_RD: begin
        if (bus.mem_rvalid) bus.write = WRITE_REG;
      end
      default: bus.busy = 1'b1;
    endcase
  end

  // Rejected opcodes leave the previous burst's fields visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= 1'b0;
      ld_q      <= 1'b0;
      invalid_q <= 1'b0;
      reg_q     <= '0;
      mem_q     <= '0;
      sel_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      invalid_q <= accept && !dec_valid;
      if (accept) begin
        cnt_q <= '0;
        if (dec_valid) begin
          st_q  <= dec_st;
          ld_q  <= dec_ld;
          reg_q <= dec_reg;
          mem_q <= dec_mem;
          sel_q <= dec_sel;
          len_q <= dec_len;
        end
      end else if (beat_done && !last_beat) begin
        cnt_q <= cnt_q + BURST_W'(1);
        mem_q <= mem_q + MEM_AW'(1);
        reg_q <= reg_q + REG_AW'(1);
      end
    end
  end

  assign bus.invalid_instruction = invalid_q;
  assign bus.mem_addr            = mem_q;
  assign bus.reg_addr            = reg_q;
  assign bus.st                  = st_q;
  assign bus.ld                  = ld_q;
  assign bus.sl_select           = sel_q;
  assign bus.sl_op               = SL_OP_DEFAULT;

endmodule

// File: tb/tb_mmu_burst_sequencer.sv
// tb/tb_mmu_burst_sequencer.sv - directed table-driven bench for mmu_burst_sequencer
module tb_mmu_burst_sequencer;
  localparam int INSTR_W = 30;
  localparam int REG_AW  = 4;
  localparam int MEM_AW  = 4;
  localparam int SEL_W   = 4;
  localparam int BURST_W = 2;

  typedef struct {
    logic       ld;
    logic       st;
    logic [3:0] regf;
    logic [3:0] memf;
    logic [3:0] self;
    logic [1:0] len;
    int         rv_delay;
    int         stall_beat;
    int         stall_cyc;
    logic       exp_valid;
    logic [3:0] exp_last_mem;
    logic [3:0] exp_last_reg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  mmu_burst_sequencer_if #(
    .INSTR_W (INSTR_W), .REG_AW (REG_AW), .MEM_AW (MEM_AW), .SEL_W (SEL_W)
  ) bus ();

  mmu_burst_sequencer #(
    .INSTR_W (INSTR_W), .REG_AW (REG_AW), .MEM_AW (MEM_AW), .SEL_W (SEL_W), .BURST_W (BURST_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [3:0] r,
                              input logic [3:0] m, input logic [3:0] s, input logic [1:0] len,
                              input int rv_delay, input int stall_beat, input int stall_cyc,
                              input logic exp_valid, input logic [3:0] exp_last_mem,
                              input logic [3:0] exp_last_reg);
    vec_t v;
    v.ld = ld; v.st = st; v.regf = r; v.memf = m; v.self = s; v.len = len;
    v.rv_delay = rv_delay; v.stall_beat = stall_beat; v.stall_cyc = stall_cyc;
    v.exp_valid = exp_valid; v.exp_last_mem = exp_last_mem; v.exp_last_reg = exp_last_reg;
    return v;
  endfunction

  // Reserved upper bits carry random junk that must not affect decoding.
  function automatic logic [INSTR_W-1:0] mk_instr(input logic ld, input logic st,
                                                  input logic [3:0] r, input logic [3:0] m,
                                                  input logic [3:0] s, input logic [1:0] len);
    logic [INSTR_W-1:0] v;
    v = INSTR_W'($urandom);
    v[15:0] = {len, s, m, r, ld, st};
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_invalid"},  bus.invalid_instruction, 0);
    check({tag, "_req"},      bus.mem_req_valid, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_reg_addr"}, bus.reg_addr, 0);
    check({tag, "_st"},       bus.st, 0);
    check({tag, "_ld"},       bus.ld, 0);
    check({tag, "_sel"},      bus.sl_select, 0);
    check({tag, "_write"},    bus.write, 0);
    check({tag, "_busy"},     bus.busy, 0);
    check({tag, "_sl_op"},    bus.sl_op, 3'b111);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] em, er;
    check("start_ready", bus.in_ready, 1);
    bus.instruction = mk_instr(v.ld, v.st, v.regf, v.memf, v.self, v.len);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (!v.exp_valid) begin
      check("inv_pulse", bus.invalid_instruction, 1);
      check("inv_noreq", bus.mem_req_valid, 0);
      check("inv_ready", bus.in_ready, 1);
      @(negedge clk);
      check("inv_once",   bus.invalid_instruction, 0);
      check("inv_noreq2", bus.mem_req_valid, 0);
      check("inv_ready2", bus.in_ready, 1);
    end else begin
      for (int b = 0; b <= int'(v.len); b++) begin
        em = v.memf + 4'(b);
        er = v.regf + 4'(b);
        check("req_valid", bus.mem_req_valid, 1);
        check("mem_addr",  bus.mem_addr, em);
        check("reg_addr",  bus.reg_addr, er);
        check("st",        bus.st, v.st);
        check("ld",        bus.ld, v.ld);
        check("sl_select", bus.sl_select, v.self);
        check("busy_ready", bus.in_ready, 0);
        check("busy",      bus.busy, 1);
        check("issue_write", bus.write, 0);
        if (b == v.stall_beat) begin
          for (int c = 0; c < v.stall_cyc; c++) begin
            bus.mem_req_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", bus.mem_req_valid, 1);
            check("stall_mem",   bus.mem_addr, em);
            check("stall_reg",   bus.reg_addr, er);
          end
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        if (v.ld) begin
          for (int d = 0; d < v.rv_delay; d++) begin
            check("wait_noreq", bus.mem_req_valid, 0);
            check("wait_write", bus.write, 0);
            @(negedge clk);
          end
          bus.mem_rvalid = 1'b1;
          #1;
          check("load_write", bus.write, 2'b10);
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
        end
      end
      check("done_ready", bus.in_ready, 1);
      check("done_busy",  bus.busy, 0);
      check("done_write", bus.write, 0);
      check("hold_mem",   bus.mem_addr, v.exp_last_mem);
      check("hold_reg",   bus.reg_addr, v.exp_last_reg);
      check("hold_st",    bus.st, v.st);
    end
  endtask

  initial begin
    //            ld    st    reg   mem   sel   len  rvd stb stc valid last_mem last_reg
    vecs[0] = mk(1'b0, 1'b1, 4'd3,  4'd5,  4'd6, 2'd0, 0, -1, 0, 1'b1, 4'd5,  4'd3);
    vecs[1] = mk(1'b1, 1'b0, 4'd2,  4'd14, 4'd9, 2'd3, 1, -1, 0, 1'b1, 4'd1,  4'd5);
    vecs[2] = mk(1'b0, 1'b0, 4'd1,  4'd1,  4'd1, 2'd1, 0, -1, 0, 1'b0, 4'd0,  4'd0);
    vecs[3] = mk(1'b1, 1'b1, 4'd4,  4'd4,  4'd4, 2'd2, 0, -1, 0, 1'b0, 4'd0,  4'd0);
    vecs[4] = mk(1'b0, 1'b1, 4'd7,  4'd9,  4'd2, 2'd2, 0,  1, 3, 1'b1, 4'd11, 4'd9);
    vecs[5] = mk(1'b1, 1'b0, 4'd15, 4'd0,  4'd12, 2'd1, 0, -1, 0, 1'b1, 4'd1, 4'd0);
    vecs[6] = mk(1'b0, 1'b1, 4'd14, 4'd15, 4'd5, 2'd3, 0, -1, 0, 1'b1, 4'd2,  4'd1);

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.instruction = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("por_ready", bus.in_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while a load beat waits for data.
    bus.instruction = mk_instr(1'b1, 1'b0, 4'd2, 4'd9, 4'd5, 2'd3);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("mid_waitrd", bus.mem_req_valid, 0);
    check("mid_busy",   bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready", bus.in_ready, 1);
    run_vec(vecs[0]);

    // Held in_valid across a store burst, with stray rvalid during ISSUE.
    bus.instruction = mk_instr(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 2'd1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.instruction = mk_instr(1'b1, 1'b0, 4'd4, 4'd6, 4'd8, 2'd0);
    bus.mem_rvalid = 1'b1;
    #1;
    check("spur_write", bus.write, 0);
    check("spur_req",   bus.mem_req_valid, 1);
    check("spur_mem",   bus.mem_addr, 4'd2);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("spur_hold",  bus.mem_addr, 4'd2);
    check("spur_ready", bus.in_ready, 0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check("held_b1_mem", bus.mem_addr, 4'd3);
    check("held_b1_reg", bus.reg_addr, 4'd2);
    check("held_b1_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("held_idle",   bus.in_ready, 1);
    check("held_mem",    bus.mem_addr, 4'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("second_req",  bus.mem_req_valid, 1);
    check("second_ld",   bus.ld, 1);
    check("second_mem",  bus.mem_addr, 4'd6);
    check("second_reg",  bus.reg_addr, 4'd4);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid = 1'b1;
    #1;
    check("second_write", bus.write, 2'b10);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("second_done", bus.in_ready, 1);
    check("second_nowr", bus.write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
